slave_port_arbiter: RTL
=======================

Name: slave_port_arbiter

Overview:
- Shares one slave port of the router between N_MASTERS masters.
- Arbitrates round-robin, drives one command at a time onto the slave req/ack handshake, and acknowledges the winning master.
- Records the master id of every issued read in an order FIFO so that in-order slave read responses route back to the right master.
- Sits on the slave side of the crossbar, one instance per slave.

Parameters:
- N_MASTERS, 4, number of requesting masters (power of 2, 2..4)
- ADDR_WIDTH, 32, command address width
- DATA_WIDTH, 32, write/read data width
- ORD_FIFO_EXP, 3, log2 depth of the read-order FIFO (depth 8)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- m_req  in  N_MASTERS  per-master command request; held until that master's m_ack
- m_cmd  in  N_MASTERS  per-master command type; 0 = read, 1 = write
- m_addr  in  N_MASTERS*ADDR_WIDTH  per-master address, master i at slice i
- m_wdata  in  N_MASTERS*DATA_WIDTH  per-master write data
- m_ack  out  N_MASTERS  one-cycle acceptance pulse to the granted master
- m_resp_valid  out  N_MASTERS  one-cycle read-response pulse to the owning master
- m_rdata  out  DATA_WIDTH  read data, valid with m_resp_valid
- s_req  out  1  slave command request
- s_cmd  out  1  slave command type
- s_addr  out  ADDR_WIDTH  slave address
- s_wdata  out  DATA_WIDTH  slave write data
- s_ack  in  1  slave accepts the command while s_req = 1
- s_resp  in  1  slave read-response pulse; responses arrive in issue order
- s_rdata  in  DATA_WIDTH  slave read data, valid with s_resp
- resp_err  out  1  sticky: s_resp received while the order FIFO was empty

Behaviour:
- Reset values:
  - all outputs 0
  - FSM = IDLE
  - RR pointer = 0
  - order FIFO empty
  - resp_err = 0
- Reset mid-transaction aborts everything: s_req drops on the next cycle and pending order entries are discarded.
- FSM states: IDLE, ISSUE, DONE.
- IDLE:
  - Eligible master i: m_req[i]=1, and either m_cmd[i]=1 or the order FIFO is not full.
  - Grant goes to the first eligible master at or after the RR pointer, wrapping modulo N_MASTERS.
  - On grant at the clock edge: latch id g, cmd, addr and wdata into the slave output registers; set s_req=1; go to ISSUE.
  - No eligible master: stay in IDLE.
- ISSUE:
  - Hold s_req and s_cmd/s_addr/s_wdata stable.
  - On s_ack=1: s_req <= 0; m_ack[g] <= 1; RR pointer <= (g+1) mod N_MASTERS; if s_cmd=0, push g into the order FIFO; go to DONE.
  - s_ack while not in ISSUE is ignored.
- DONE: m_ack[g] <= 0; go to IDLE. m_ack is high for exactly the DONE cycle.
- Best-case latency: req sampled at edge 0 -> s_req high from edge 1 -> s_ack in the same cycle -> m_ack in cycle 2 -> IDLE in cycle 3. Throughput is 1 command per 3 cycles minimum.
- Masters deassert or change req at the edge ending DONE, so IDLE never re-grants a stale request.
- Response path:
  - On s_resp=1 with the FIFO not empty: m_rdata <= s_rdata; m_resp_valid[head] <= 1 for one cycle (latency 1); pop.
  - On s_resp=1 with the FIFO empty: drop the data; resp_err <= 1 until reset.
- Push and pop in the same cycle are both performed; occupancy is unchanged. Push while full is impossible because reads are gated at grant.
- Writes bypass the FIFO and are never stalled by FIFO full.
- The RR pointer advances only on a completed grant (s_ack), never on an idle cycle.

Decomposition:
- Package router_pkg:
  - MASTER_ID_W = $clog2(N_MASTERS)
  - CMD_RD = 1'b0, CMD_WR = 1'b1
  - typedef enum logic [1:0] {IDLE, ISSUE, DONE} arb_state_t
- Sub-module rr_arbiter: request vector, pointer and advance in; grant one-hot, id and valid out; owns the pointer register.
- Order FIFO: the team's existing fifo through fifo_if, DATA_WIDTH = MASTER_ID_W, FIFO_SIZE_EXP = ORD_FIFO_EXP.

Test Plan:
- All four masters issue a read at the same cycle, pointer 0, s_ack immediate -> slave sees masters 0,1,2,3 in that order; m_ack pulses 3 cycles apart; FIFO holds 0,1,2,3.
- Four s_resp pulses with data 0xA0..0xA3 -> m_resp_valid asserted for masters 0,1,2,3 in turn, each 1 cycle after its s_resp, with m_rdata = 0xA0..0xA3.
- Fill the FIFO with 8 reads and no responses; master 1 requests a read and master 2 a write -> master 2 is granted, master 1 stalls. One s_resp -> master 1 is granted next.
- s_ack held low for 10 cycles in ISSUE -> s_req and s_addr stable throughout; no m_ack until the cycle after s_ack.
- s_resp with the FIFO empty -> no m_resp_valid; resp_err = 1 until rst.
- rst asserted in ISSUE with 3 reads outstanding -> next cycle s_req = 0, FSM = IDLE, FIFO empty, pointer = 0, resp_err = 0.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types and constants for the router slave-side blocks.
package router_pkg;

  localparam int  N_MASTERS_DEFAULT = 4;
  localparam int  MASTER_ID_W       = $clog2(N_MASTERS_DEFAULT);

  localparam logic CMD_RD = 1'b0;
  localparam logic CMD_WR = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } arb_state_t;

endpackage

// File: rtl/fifo_if.sv
// Push/pop port of the generic show-ahead fifo.
interface fifo_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  full;
  logic                  empty;

  modport master (output push, pop, wdata, input rdata, full, empty);
  modport slave  (input push, pop, wdata, output rdata, full, empty);
endinterface

// File: rtl/slave_port_arbiter_if.sv
// Master-side command/response bundle plus the single slave req/ack port.
interface slave_port_arbiter_if #(
  parameter int N_MASTERS  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [N_MASTERS-1:0]            m_req;
  logic [N_MASTERS-1:0]            m_cmd;
  logic [N_MASTERS*ADDR_WIDTH-1:0] m_addr;
  logic [N_MASTERS*DATA_WIDTH-1:0] m_wdata;
  logic [N_MASTERS-1:0]            m_ack;
  logic [N_MASTERS-1:0]            m_resp_valid;
  logic [DATA_WIDTH-1:0]           m_rdata;
  logic                            s_req;
  logic                            s_cmd;
  logic [ADDR_WIDTH-1:0]           s_addr;
  logic [DATA_WIDTH-1:0]           s_wdata;
  logic                            s_ack;
  logic                            s_resp;
  logic [DATA_WIDTH-1:0]           s_rdata;
  logic                            resp_err;

  // Arbiter side.
  modport slave (
    input  m_req, m_cmd, m_addr, m_wdata, s_ack, s_resp, s_rdata,
    output m_ack, m_resp_valid, m_rdata, s_req, s_cmd, s_addr, s_wdata, resp_err
  );

  // Environment side: the masters and the slave device.
  modport master (
    output m_req, m_cmd, m_addr, m_wdata, s_ack, s_resp, s_rdata,
    input  m_ack, m_resp_valid, m_rdata, s_req, s_cmd, s_addr, s_wdata, resp_err
  );
endinterface

// File: rtl/fifo.sv
// Generic show-ahead fifo, 2**FIFO_SIZE_EXP entries; rdata is the head while !empty.
// Push when full and pop when empty are ignored; simultaneous push/pop keeps occupancy.
module fifo #(
  parameter int DATA_WIDTH    = 8,
  parameter int FIFO_SIZE_EXP = 3
) (
  input logic clk,
  input logic rst,
  fifo_if.slave f
);
  localparam int DEPTH = 1 << FIFO_SIZE_EXP;
  localparam logic [FIFO_SIZE_EXP:0] PTR_ONE = 1;

  logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
  logic [DATA_WIDTH-1:0]  mem_d [DEPTH];
  logic [FIFO_SIZE_EXP:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_SIZE_EXP:0] rd_ptr_q, rd_ptr_d;
  logic                   do_push, do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign f.empty = (wr_ptr_q == rd_ptr_q);
  assign f.full  = (wr_ptr_q[FIFO_SIZE_EXP] != rd_ptr_q[FIFO_SIZE_EXP]) &&
                   (wr_ptr_q[FIFO_SIZE_EXP-1:0] == rd_ptr_q[FIFO_SIZE_EXP-1:0]);
  assign f.rdata = mem_q[rd_ptr_q[FIFO_SIZE_EXP-1:0]];

  assign do_push = f.push & ~f.full;
  assign do_pop  = f.pop  & ~f.empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[FIFO_SIZE_EXP-1:0]] = f.wdata;
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin pick of the first request at or after the pointer; combinational grant.
// The pointer moves to adv_id+1 only when advance is pulsed.
module rr_arbiter #(
  parameter int N    = 4,
  localparam int ID_W = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            advance,
  input  logic [ID_W-1:0] adv_id,
  output logic [N-1:0]    gnt_oh,
  output logic [ID_W-1:0] gnt_id,
  output logic            gnt_vld
);
  localparam logic [ID_W-1:0] ID_ONE = 1;

  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] idx;

  // Scan from farthest to nearest so the nearest request is the last written.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    gnt_oh  = '0;
    idx     = '0;
    for (int off = N - 1; off >= 0; off--) begin
      idx = ptr_q + ID_W'(off);
      if (req[idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = idx;
      end
    end
    gnt_oh[gnt_id] = gnt_vld;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = adv_id + ID_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
endmodule

// File: rtl/slave_port_arbiter.sv
// Shares one slave port between N_MASTERS masters: round-robin grant, one command per 3 cycles,
// and in-order routing of read responses via a fifo of issued master ids.
module slave_port_arbiter
  import router_pkg::*;
#(
  parameter int N_MASTERS    = 4,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int ORD_FIFO_EXP = 3
) (
  input logic clk,
  input logic rst,
  slave_port_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(N_MASTERS);

  arb_state_t            state_q, state_d;
  logic [ID_W-1:0]       gnt_id_q, gnt_id_d;
  logic                  s_req_q, s_req_d;
  logic                  s_cmd_q, s_cmd_d;
  logic [ADDR_WIDTH-1:0] s_addr_q, s_addr_d;
  logic [DATA_WIDTH-1:0] s_wdata_q, s_wdata_d;
  logic [N_MASTERS-1:0]  m_ack_q, m_ack_d;
  logic [N_MASTERS-1:0]  m_resp_valid_q, m_resp_valid_d;
  logic [DATA_WIDTH-1:0] m_rdata_q, m_rdata_d;
  logic                  resp_err_q, resp_err_d;

  logic [N_MASTERS-1:0]  eligible;
  logic [N_MASTERS-1:0]  arb_gnt_oh;
  logic [ID_W-1:0]       arb_gnt_id;
  logic                  arb_gnt_vld;
  logic                  arb_advance;
  logic                  ord_push, ord_pop;

  fifo_if #(.DATA_WIDTH(ID_W)) ord_if ();

  fifo #(
    .DATA_WIDTH   (ID_W),
    .FIFO_SIZE_EXP(ORD_FIFO_EXP)
  ) u_ord_fifo (
    .clk(clk),
    .rst(rst),
    .f  (ord_if)
  );

  // Reads need a free order slot at grant time; writes never touch the fifo.
  assign eligible = bus.m_req & (bus.m_cmd | {N_MASTERS{~ord_if.full}});

  rr_arbiter #(.N(N_MASTERS)) u_rr (
    .clk    (clk),
    .rst    (rst),
    .req    (eligible),
    .advance(arb_advance),
    .adv_id (gnt_id_q),
    .gnt_oh (arb_gnt_oh),
    .gnt_id (arb_gnt_id),
    .gnt_vld(arb_gnt_vld)
  );

  assign ord_if.push  = ord_push;
  assign ord_if.pop   = ord_pop;
  assign ord_if.wdata = gnt_id_q;

  always_comb begin
    state_d        = state_q;
    gnt_id_d       = gnt_id_q;
    s_req_d        = s_req_q;
    s_cmd_d        = s_cmd_q;
    s_addr_d       = s_addr_q;
    s_wdata_d      = s_wdata_q;
    m_ack_d        = '0;
    m_resp_valid_d = '0;
    m_rdata_d      = m_rdata_q;
    resp_err_d     = resp_err_q;
    arb_advance    = 1'b0;
    ord_push       = 1'b0;
    ord_pop        = 1'b0;

    case (state_q)
      IDLE: begin
        if (arb_gnt_vld) begin
          gnt_id_d  = arb_gnt_id;
          s_req_d   = 1'b1;
          s_cmd_d   = |(bus.m_cmd & arb_gnt_oh);
          s_addr_d  = bus.m_addr[arb_gnt_id*ADDR_WIDTH +: ADDR_WIDTH];
          s_wdata_d = bus.m_wdata[arb_gnt_id*DATA_WIDTH +: DATA_WIDTH];
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.s_ack) begin
          s_req_d           = 1'b0;
          m_ack_d[gnt_id_q] = 1'b1;
          arb_advance       = 1'b1;
          ord_push          = (s_cmd_q == CMD_RD);
          state_d           = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Slave responses come back in issue order, so the fifo head owns this one.
    if (bus.s_resp) begin
      if (!ord_if.empty) begin
        m_rdata_d                    = bus.s_rdata;
        m_resp_valid_d[ord_if.rdata] = 1'b1;
        ord_pop                      = 1'b1;
      end else begin
        resp_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      gnt_id_q       <= '0;
      s_req_q        <= 1'b0;
      s_cmd_q        <= 1'b0;
      s_addr_q       <= '0;
      s_wdata_q      <= '0;
      m_ack_q        <= '0;
      m_resp_valid_q <= '0;
      m_rdata_q      <= '0;
      resp_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      gnt_id_q       <= gnt_id_d;
      s_req_q        <= s_req_d;
      s_cmd_q        <= s_cmd_d;
      s_addr_q       <= s_addr_d;
      s_wdata_q      <= s_wdata_d;
      m_ack_q        <= m_ack_d;
      m_resp_valid_q <= m_resp_valid_d;
      m_rdata_q      <= m_rdata_d;
      resp_err_q     <= resp_err_d;
    end
  end

  assign bus.s_req        = s_req_q;
  assign bus.s_cmd        = s_cmd_q;
  assign bus.s_addr       = s_addr_q;
  assign bus.s_wdata      = s_wdata_q;
  assign bus.m_ack        = m_ack_q;
  assign bus.m_resp_valid = m_resp_valid_q;
  assign bus.m_rdata      = m_rdata_q;
  assign bus.resp_err     = resp_err_q;
endmodule
